gcd_datapath: RTL

GCD_DATAPATH -- requirements
Module: gcd_datapath

---
 rtl/gcd_datapath_if.sv | 26 ++
 rtl/gcd_datapath.sv | 67 ++++++
 2 files changed

// File: rtl/gcd_datapath_if.sv
// Bus between the GCD controller and its datapath: register-file addressing,
// write control, ALU function select, read data and the registered flags.
interface gcd_datapath_if;
  logic [3:0]  raddr1;
  logic [3:0]  raddr2;
  logic        wen;
  logic [3:0]  waddr;
  logic        wdsrc;
  logic [3:0]  func;
  logic [31:0] constant;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] alu_out;
  logic        isZero;
  logic        isLess;

  modport master (
    output raddr1, raddr2, wen, waddr, wdsrc, func, constant,
    input  rdata1, rdata2, alu_out, isZero, isLess
  );

  modport slave (
    input  raddr1, raddr2, wen, waddr, wdsrc, func, constant,
    output rdata1, rdata2, alu_out, isZero, isLess
  );
endinterface

// File: rtl/gcd_datapath.sv
// GCD datapath: 16 x 32-bit register file with two asynchronous read ports,
// one synchronous write port, a combinational ALU and registered zero/less
// flags that the controller consumes one cycle after issuing an operation.
module gcd_datapath #(
  parameter int NREGS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  gcd_datapath_if.slave bus
);

  localparam int DATA_W = 32;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wdata;
  logic              less;

  // ALU: all arithmetic is modulo 2^32; reserved codes yield zero
  function automatic logic [DATA_W-1:0] alu(
    input logic [3:0]        f,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] y;
    case (f)
      4'd0:    y = a + b;
      4'd1:    y = a - b;
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      4'd4:    y = a ^ b;
      4'd5:    y = a;
      4'd6:    y = b;
      4'd7:    y = {{(DATA_W-1){1'b0}}, (a < b)};
      4'd8:    y = {a[DATA_W-2:0], 1'b0};
      4'd9:    y = {1'b0, a[DATA_W-1:1]};
      default: y = '0;
    endcase
    return y;
  endfunction

  assign bus.rdata1  = regs[bus.raddr1];
  assign bus.rdata2  = regs[bus.raddr2];
  assign bus.alu_out = alu(bus.func, bus.rdata1, bus.rdata2);
  assign less        = (bus.rdata1 < bus.rdata2);
  assign wdata       = bus.wdsrc ? bus.constant : bus.alu_out;

  // Register file write; reset clears every entry without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wen) begin
      regs[bus.waddr] <= wdata;
    end
  end

  // Flags track every ALU operation (wdsrc=0) from pre-edge operands, hold on constant loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.isZero <= 1'b1;
      bus.isLess <= 1'b0;
    end else if (!bus.wdsrc) begin
      bus.isZero <= (bus.alu_out == '0);
      bus.isLess <= less;
    end
  end

endmodule
